host_burst_rw: RTL

//  Parametrised host-side DDR3 access engine. Runs one single- or multi-beat Avalon-MM burst

---
 rtl/host_burst_rw.sv | 139 +++++++++++++
 1 files changed

// File: rtl/host_burst_rw.sv
// Avalon-MM burst read/write engine: one burst per cmd_start rising edge, read beats out registered (1 cycle).
// Write beats flow through combinationally under waitrequest; a stall counter aborts a burst that stops progressing.
module host_burst_rw #(
    parameter int ADDRESS_SIZE = 27,
    parameter int DATA_W       = 576,
    parameter int BURST_W      = 7,
    parameter int MAX_BURST    = 64,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                    ddr3_clk,
    input  logic                    ddr3_reset_n,
    output logic [ADDRESS_SIZE-1:0] host_m0_address,
    output logic                    host_m0_read,
    output logic                    host_m0_write,
    output logic [DATA_W-1:0]       host_m0_writedata,
    output logic [DATA_W/8-1:0]     host_m0_be,
    output logic [BURST_W-1:0]      host_m0_burstcount,
    input  logic                    host_m0_waitrequest,
    input  logic [DATA_W-1:0]       host_m0_readdata,
    input  logic                    host_m0_readdatavalid,
    input  logic                    cmd_start,
    input  logic                    cmd_read,
    input  logic [ADDRESS_SIZE-1:0] cmd_addr,
    input  logic [BURST_W-1:0]      cmd_len,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [3:0]              host_status
);

    localparam int STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_BURST} state_t;

    state_t                  state_q;
    logic                    cmd_start_d_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [BURST_W-1:0]      len_q;
    logic [BURST_W-1:0]      cnt_q;
    logic                    read_q;
    logic [DATA_W-1:0]       rd_data_q;
    logic                    rd_valid_q;
    logic [3:1]              status_q;
    logic [STALL_W-1:0]      stall_q;

    logic start_p, len_bad, wr_beat, rd_acc, rd_beat, last_beat, progress, timeout_hit;

    assign start_p     = cmd_start & ~cmd_start_d_q;
    assign len_bad     = (cmd_len == '0) || (int'(cmd_len) > MAX_BURST);
    assign wr_beat     = (state_q == WR_BURST) & wr_valid & ~host_m0_waitrequest;
    assign rd_acc      = read_q & ~host_m0_waitrequest;
    assign rd_beat     = ((state_q == RD_REQ) || (state_q == RD_DATA)) & host_m0_readdatavalid;
    assign last_beat   = (rd_beat | wr_beat) && (cnt_q + 1'b1 == len_q);
    assign progress    = rd_acc | rd_beat | wr_beat;
    assign timeout_hit = (TIMEOUT_CYC != 0) && !progress && (int'(stall_q) == TIMEOUT_CYC - 1);

    assign host_m0_address    = addr_q;
    assign host_m0_read       = read_q;
    assign host_m0_write      = (state_q == WR_BURST) & wr_valid;
    assign host_m0_writedata  = wr_data;
    assign host_m0_be         = '1;
    assign host_m0_burstcount = len_q;
    assign wr_ready           = wr_beat;
    assign rd_data            = rd_data_q;
    assign rd_valid           = rd_valid_q;
    assign host_status        = {status_q, state_q != IDLE};

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            state_q       <= IDLE;
            cmd_start_d_q <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            read_q        <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            status_q      <= '0;
            stall_q       <= '0;
        end else begin
            cmd_start_d_q <= cmd_start;
            rd_valid_q    <= 1'b0;
            if (rd_beat) begin
                rd_data_q  <= host_m0_readdata;
                rd_valid_q <= 1'b1;
            end
            if (rd_beat | wr_beat) cnt_q <= cnt_q + 1'b1;
            if (state_q == IDLE || progress) stall_q <= '0;
            else if (TIMEOUT_CYC != 0)       stall_q <= stall_q + 1'b1;

            // Completion is checked before the timeout so a last beat always wins.
            case (state_q)
                IDLE: begin
                    if (start_p) begin
                        addr_q   <= cmd_addr;
                        len_q    <= cmd_len;
                        cnt_q    <= '0;
                        status_q <= len_bad ? 3'b101 : 3'b000;
                        if (!len_bad) begin
                            if (cmd_read) begin
                                state_q <= RD_REQ;
                                read_q  <= 1'b1;
                            end else begin
                                state_q <= WR_BURST;
                            end
                        end
                    end
                end
                RD_REQ, RD_DATA: begin
                    if (last_beat) begin
                        state_q     <= IDLE;
                        read_q      <= 1'b0;
                        status_q[1] <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q       <= IDLE;
                        read_q        <= 1'b0;
                        status_q[2:1] <= 2'b11;
                    end else if (rd_acc) begin
                        state_q <= RD_DATA;
                        read_q  <= 1'b0;
                    end
                end
                WR_BURST: begin
                    if (last_beat) begin
                        state_q     <= IDLE;
                        status_q[1] <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q       <= IDLE;
                        status_q[2:1] <= 2'b11;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
